// File: rtl/dz_dtr.sv
// dz_dtr -- DZ11 Transmit Control Register (TCR) and DTR modem-control driver.
//
// TCR layout is {DTR[7:0], LENA[7:0]}. Each half is written by its own byte
// strobe from the DZ11 bus decoder. Each of the eight DTR lines drives its
// modem through a small per-line FSM. That FSM enforces a minimum hang-up
// time (HOLD_CLKS clocks) after every drop, so a modem always sees a clean
// disconnect before DTR comes back.
//
// Optional feature macro: DZ_DTR_HOLD_EN
//   defined   : per-line OFF/ON/HOLD FSM with a hold-down counter.
//   undefined : dz11DTR is regTCR[15:8] delayed one clock, dtrBUSY = 0,
//               and HOLD_CLKS/CW are unused.
//
// Ports
//   clk      clock
//   rst      asynchronous reset, active-low
//   clr      synchronous master clear (CSR MCLR), active-high, beats writes
//   tcrWRL   write strobe for TCR[7:0]  (line enables)
//   tcrWRH   write strobe for TCR[15:8] (DTR requests)
//   dataIN   bus write data
//   regTCR   TCR readback
//   lineENA  per-line transmit enable (regTCR[7:0])
//   dz11DTR  registered DTR outputs to the modems
//   dtrBUSY  per-line hold timer active
module dz_dtr #(
   parameter int HOLD_CLKS = 50000,
   parameter int CW        = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        tcrWRL,
   input  logic        tcrWRH,
   input  logic [15:0] dataIN,
   output logic [15:0] regTCR,
   output logic [7:0]  lineENA,
   output logic [7:0]  dz11DTR,
   output logic [7:0]  dtrBUSY
);

   logic [15:0] tcr;

   // TCR register: master clear wins over both byte strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcr <= 16'h0000;
      end else if (clr) begin
         tcr <= 16'h0000;
      end else begin
         if (tcrWRL) tcr[7:0]  <= dataIN[7:0];
         if (tcrWRH) tcr[15:8] <= dataIN[15:8];
      end
   end

   assign regTCR  = tcr;
   assign lineENA = tcr[7:0];

`ifdef DZ_DTR_HOLD_EN

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_ON   = 2'd1,
      S_HOLD = 2'd2
   } dtr_state_t;

   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CLKS - 1);
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

   dtr_state_t    state_q [8];
   dtr_state_t    state_d [8];
   logic [CW-1:0] cnt_q   [8];
   logic [CW-1:0] cnt_d   [8];
   logic [7:0]    dtr_d;
   logic [7:0]    busy_d;

   // State, counter and output registers. The outputs are registered from
   // the next state, so they always match the state the line has just entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < 8; n++) begin
            state_q[n] <= S_OFF;
            cnt_q[n]   <= '0;
         end
         dz11DTR <= 8'h00;
         dtrBUSY <= 8'h00;
      end else begin
         for (int n = 0; n < 8; n++) begin
            state_q[n] <= state_d[n];
            cnt_q[n]   <= cnt_d[n];
         end
         dz11DTR <= dtr_d;
         dtrBUSY <= busy_d;
      end
   end

   // Per-line next state. A request seen during HOLD is ignored until the
   // counter reaches zero, and the timer never restarts mid-hold.
   always_comb begin
      dtr_d  = 8'h00;
      busy_d = 8'h00;
      for (int n = 0; n < 8; n++) begin
         state_d[n] = state_q[n];
         cnt_d[n]   = cnt_q[n];
         case (state_q[n])
            S_OFF: begin
               if (tcr[8+n]) state_d[n] = S_ON;
            end
            S_ON: begin
               if (!tcr[8+n]) begin
                  state_d[n] = S_HOLD;
                  cnt_d[n]   = HOLD_LOAD;
               end
            end
            S_HOLD: begin
               if (cnt_q[n] != '0) cnt_d[n] = cnt_q[n] - CNT_ONE;
               else                state_d[n] = tcr[8+n] ? S_ON : S_OFF;
            end
            default: begin
               state_d[n] = S_OFF;
               cnt_d[n]   = '0;
            end
         endcase
         dtr_d[n]  = (state_d[n] == S_ON);
         busy_d[n] = (state_d[n] == S_HOLD);
      end
   end

`else

   // Without hold-down, DTR simply follows the request bits one clock later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dz11DTR <= 8'h00;
      else      dz11DTR <= tcr[15:8];
   end

   assign dtrBUSY = 8'h00;

`endif

endmodule

// File: tb/tb_dz_dtr.sv
// tb_dz_dtr -- directed test of dz_dtr with HOLD_CLKS = 4. Expectations
// follow whichever build (DZ_DTR_HOLD_EN defined or not) is compiled.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_dz_dtr;

`ifdef DZ_DTR_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        tcrWRL;
   logic        tcrWRH;
   logic [15:0] dataIN;
   logic [15:0] regTCR;
   logic [7:0]  lineENA;
   logic [7:0]  dz11DTR;
   logic [7:0]  dtrBUSY;

   int n_checks = 0;
   int n_fail   = 0;

   dz_dtr #(.HOLD_CLKS(4), .CW(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .tcrWRL  (tcrWRL),
      .tcrWRH  (tcrWRH),
      .dataIN  (dataIN),
      .regTCR  (regTCR),
      .lineENA (lineENA),
      .dz11DTR (dz11DTR),
      .dtrBUSY (dtrBUSY)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; tcrWRL = 1'b0; tcrWRH = 1'b0; dataIN = 16'h0000;
      step(); step();
      chk("rst_tcr",  regTCR, 16'h0000);
      chk("rst_ena",  {8'h00, lineENA}, 16'h0000);
      chk("rst_dtr",  {8'h00, dz11DTR}, 16'h0000);
      chk("rst_busy", {8'h00, dtrBUSY}, 16'h0000);
      rst = 1'b1;
      step();
      chk("post_rst_dtr", {8'h00, dz11DTR}, 16'h0000);

      // Low byte write
      tcrWRL = 1'b1; dataIN = 16'h00A5;
      step();
      tcrWRL = 1'b0;
      chk("wrl_tcr", regTCR, 16'h00A5);
      chk("wrl_ena", {8'h00, lineENA}, 16'h00A5);
      chk("wrl_dtr", {8'h00, dz11DTR}, 16'h0000);

      // High byte write asserts lines 0 and 1 one cycle later
      tcrWRH = 1'b1; dataIN = 16'h0300;
      step();
      tcrWRH = 1'b0;
      chk("wrh_tcr", regTCR, 16'h03A5);
      chk("wrh_dtr_E", {8'h00, dz11DTR}, 16'h0000);
      step();
      chk("wrh_dtr_E1", {8'h00, dz11DTR}, 16'h0003);
      chk("wrh_busy",   {8'h00, dtrBUSY}, 16'h0000);

      // Drop both lines, re-request line 0 two cycles after the drop
      tcrWRH = 1'b1; dataIN = 16'h0000;
      step();
      tcrWRH = 1'b0;
      chk("drop_tcr", regTCR, 16'h00A5);
      chk("drop_dtr_E", {8'h00, dz11DTR}, 16'h0003);
      step();
      chk("drop_dtr_E1",  {8'h00, dz11DTR}, 16'h0000);
      chk("drop_busy_E1", {8'h00, dtrBUSY}, HOLD ? 16'h0003 : 16'h0000);
      tcrWRH = 1'b1; dataIN = 16'h0100;
      step();
      tcrWRH = 1'b0;
      chk("rereq_tcr",    regTCR, 16'h01A5);
      chk("drop_dtr_E2",  {8'h00, dz11DTR}, 16'h0000);
      chk("drop_busy_E2", {8'h00, dtrBUSY}, HOLD ? 16'h0003 : 16'h0000);
      step();
      chk("drop_dtr_E3",  {8'h00, dz11DTR}, HOLD ? 16'h0000 : 16'h0001);
      chk("drop_busy_E3", {8'h00, dtrBUSY}, HOLD ? 16'h0003 : 16'h0000);
      step();
      chk("drop_dtr_E4",  {8'h00, dz11DTR}, HOLD ? 16'h0000 : 16'h0001);
      chk("drop_busy_E4", {8'h00, dtrBUSY}, HOLD ? 16'h0003 : 16'h0000);
      step();
      chk("drop_dtr_E5",  {8'h00, dz11DTR}, 16'h0001);
      chk("drop_busy_E5", {8'h00, dtrBUSY}, 16'h0000);

      // Master clear with all DTR on
      tcrWRH = 1'b1; dataIN = 16'hFF00;
      step();
      tcrWRH = 1'b0;
      chk("all_tcr", regTCR, 16'hFFA5);
      step();
      chk("all_dtr", {8'h00, dz11DTR}, 16'h00FF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_tcr",   regTCR, 16'h0000);
      chk("clr_dtr_C", {8'h00, dz11DTR}, 16'h00FF);
      step();
      chk("clr_dtr_C1",  {8'h00, dz11DTR}, 16'h0000);
      chk("clr_busy_C1", {8'h00, dtrBUSY}, HOLD ? 16'h00FF : 16'h0000);
      step(); step();
      chk("clr_busy_C3", {8'h00, dtrBUSY}, HOLD ? 16'h00FF : 16'h0000);
      step();
      chk("clr_busy_C4", {8'h00, dtrBUSY}, HOLD ? 16'h00FF : 16'h0000);
      step();
      chk("clr_busy_C5", {8'h00, dtrBUSY}, 16'h0000);
      chk("clr_dtr_C5",  {8'h00, dz11DTR}, 16'h0000);

      // Async reset two cycles into HOLD
      tcrWRH = 1'b1; dataIN = 16'h0100;
      step();
      tcrWRH = 1'b0;
      step();
      chk("ar_on_dtr", {8'h00, dz11DTR}, 16'h0001);
      tcrWRH = 1'b1; dataIN = 16'h0000;
      step();
      tcrWRH = 1'b0;
      step();
      step();
      chk("ar_hold_busy", {8'h00, dtrBUSY}, HOLD ? 16'h0001 : 16'h0000);
      #2 rst = 1'b0;
      #1;
      chk("ar_busy_now", {8'h00, dtrBUSY}, 16'h0000);
      chk("ar_dtr_now",  {8'h00, dz11DTR}, 16'h0000);
      chk("ar_tcr_now",  regTCR, 16'h0000);
      step();
      rst = 1'b1;
      tcrWRH = 1'b1; dataIN = 16'h0100;
      step();
      tcrWRH = 1'b0;
      chk("ar_rewr_dtr_E", {8'h00, dz11DTR}, 16'h0000);
      step();
      chk("ar_rewr_dtr_E1",  {8'h00, dz11DTR}, 16'h0001);
      chk("ar_rewr_busy_E1", {8'h00, dtrBUSY}, 16'h0000);

      // Both strobes in one cycle load the full word
      tcrWRL = 1'b1; tcrWRH = 1'b1; dataIN = 16'h5A3C;
      step();
      tcrWRL = 1'b0; tcrWRH = 1'b0;
      chk("both_tcr", regTCR, 16'h5A3C);
      chk("both_ena", {8'h00, lineENA}, 16'h003C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
